// File: rtl/simple_mem_pkg.sv
// simple_mem_pkg: shared widths, latency bound and responder FSM states for simple_mem_resp
package simple_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/simple_mem_array.sv
// simple_mem_array: 256 x 8 store, synchronous write, combinational read, contents untouched by reset
module simple_mem_array
  import simple_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/simple_mem_resp.sv
// simple_mem_resp: memory responder with LATENCY wait cycles and a one-cycle mem_ready pulse.
// Define SIMPLE_MEM_WP_EN to block writes to PROT_LO..PROT_HI and flag them on wp_err.
module simple_mem_resp
  import simple_mem_pkg::*;
#(
  parameter int unsigned       LATENCY = 2,
  parameter logic [ADDR_W-1:0] PROT_LO = 8'hF0,
  parameter logic [ADDR_W-1:0] PROT_HI = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              wp_err,
  output logic [7:0]        acc_cnt
);
`ifdef SIMPLE_MEM_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr, addr_off;
  logic [DATA_W-1:0] wdata_q, wdata_d, cur_wdata, rdata_q, rdata_d, arr_rdata;
  logic [7:0] acc_q, acc_d;
  logic we_q, we_d, cur_we, wp_q, wp_d, idle, commit, blocked, arr_we;
  // With LATENCY 0 the commit edge is the acceptance edge, so the live inputs are used in IDLE
  always_comb begin
    idle = state_q == IDLE;
    cur_addr = idle ? mem_addr : addr_q;
    cur_we = idle ? mem_we : we_q;
    cur_wdata = idle ? mem_wdata : wdata_q;
    addr_off = cur_addr - PROT_LO;
    blocked = WP_EN & cur_we & (addr_off <= PROT_HI - PROT_LO);
    commit = !rst & mem_req & (idle ? (LATENCY == 0) : (state_q == WAIT && cnt_q <= CNT_W'(1)));
    arr_we = commit & cur_we & !blocked;
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    if (idle && mem_req) begin
      addr_d = mem_addr;
      we_d = mem_we;
      wdata_d = mem_wdata;
      cnt_d = CNT_W'(LATENCY);
      state_d = commit ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = mem_req ? cnt_q - CNT_W'(1) : '0;
      state_d = !mem_req ? IDLE : commit ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    rdata_d = commit ? (arr_we ? cur_wdata : arr_rdata) : rdata_q;
    wp_d = commit & blocked;
    acc_d = acc_q + 8'(commit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      wp_q <= 1'b0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wp_q <= wp_d;
      acc_q <= acc_d;
    end
  end
  simple_mem_array u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );
  assign mem_ready = state_q == RESP;
  assign mem_rdata = rdata_q;
  assign wp_err = wp_q;
  assign acc_cnt = acc_q;
endmodule
